bias_bank_add: RTL and testbench
================================

Name: bias_bank_add

Overview:
- Parametrised successor to the fixed-constant per-layer bias banks.
- Holds N_SETS runtime-loadable bias sets, each with N_ADDER_TREE lanes of DATA_W bits.
- Adds the selected set to an adder-tree output vector, then applies saturation and optional ReLU.
- Sits between the adder tree and the layer output buffer; one instance serves every filter group of a layer.

Parameters:
- N_ADDER_TREE, 16, lanes per vector.
- DATA_W, 18, two's-complement width of bias, input and output.
- N_SETS, 32, number of bias sets (filter groups).
- SET_W, $clog2(N_SETS), set index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  begin loading set ld_set; sampled only in IDLE.
- ld_set  in  SET_W  set index to load.
- ld_valid  in  1  bias word valid.
- ld_ready  out  1  bias word accepted.
- ld_data  in  DATA_W  bias word; lane 0 first.
- ld_done  out  1  one-cycle pulse after the last lane is written.
- relu_en  in  1  static mode: clamp negative results to 0.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted.
- in_set  in  SET_W  bias set for this vector.
- in_data  in  N_ADDER_TREE*DATA_W  lane i at [DATA_W*(i+1)-1 : DATA_W*i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N_ADDER_TREE*DATA_W  result, same lane packing as in_data.

Behaviour:
- Reset, synchronous, at any time:
  - Outputs: out_valid=0, out_data=0, ld_ready=0, ld_done=0.
  - Load FSM goes to IDLE, lane counter=0, all bias registers=0.
  - A load or transfer in progress is abandoned; no partial state survives.
- Load FSM, IDLE:
  - ld_ready=0.
  - ld_start=1 latches ld_set, clears the lane counter and moves to LOAD.
- Load FSM, LOAD:
  - ld_ready=1.
  - Each ld_valid&&ld_ready writes ld_data to bias[set][lane] and increments the lane counter.
  - On the write to lane N_ADDER_TREE-1, moves to DONE.
- Load FSM, DONE:
  - ld_done=1 for exactly one cycle, ld_ready=0, then returns to IDLE.
  - ld_start asserted in DONE is ignored.
- Compute path: single register stage, latency 1 cycle.
  - in_ready = (!out_valid || out_ready) && !(state==LOAD && in_set==loading set).
  - Loading set k never stalls vectors that use other sets.
  - On in_valid&&in_ready, per lane: sum = sext(in)+sext(bias[in_set][i]) at DATA_W+1 bits.
  - sum > 2^(DATA_W-1)-1 gives 2^(DATA_W-1)-1; sum < -2^(DATA_W-1) gives -2^(DATA_W-1); otherwise the low DATA_W bits.
  - If relu_en=1 and the result is negative, output 0. Saturation is applied before ReLU.
  - Result registers into out_data with out_valid=1.
  - out_valid=1 && out_ready=0: out_data holds and in_ready=0.
  - out_ready=1 with a new accept: back-to-back throughput of 1 vector/cycle.
  - out_ready=1 with no accept: out_valid drops to 0 next cycle.
- Simultaneous events:
  - A vector using set k in the cycle the DONE transition fires (last lane of k written) is not possible, because in_ready is 0 for set k during LOAD.
  - Vectors accepted in DONE and later use the new set.
  - Sets other than k read their old, unchanged values throughout.
- Out-of-range indices (in_set or ld_set >= N_SETS when N_SETS is not a power of two):
  - Load is accepted; writes are discarded.
  - Compute uses a bias of 0.

Decomposition:
- Shared package bias_pkg holds:
  - DATA_W default.
  - Lane pack/unpack helper function.
  - Load-FSM state enum {IDLE, LOAD, DONE}.
  - Function sat_add(a,b) returning the saturated DATA_W result.
- One natural sub-module, bias_lane_sat: a single-lane combinational add, saturate and ReLU, instantiated N_ADDER_TREE times in a generate loop.
- Bias storage and FSM stay in the top module.

Test Plan:
- Reset, then load set 3 with lanes i = i*4.
  - ld_done pulses once, exactly N_ADDER_TREE+1 cycles after ld_start with ld_valid held high.
  - A vector of all 100 on set 3 returns lanes 100+4i one cycle later.
- Saturation:
  - Bias lane0 = 131071, input 10 gives 131071.
  - Bias -131072, input -5 gives -131072.
  - With relu_en=1, input -20 and bias 5 gives 0.
- Backpressure:
  - Stream 8 vectors with out_ready low for cycles 2-4.
  - Expect no loss or duplication, out_data stable while stalled, then 1/cycle throughput.
- Load/compute overlap:
  - Load set 5 while issuing vectors on sets 5 and 6.
  - Set-6 vectors flow; set-5 vectors stall (in_ready=0) until the DONE cycle, then use the new values.
- Reset mid-load after 7 lanes:
  - ld_ready goes to 0 and the FSM returns to IDLE.
  - A subsequent vector on any set sees bias 0 in every lane.
- Load with ld_valid gaps (valid on alternate cycles) ends with correct lane ordering; ld_start pulsed during LOAD is ignored.

Source files
------------

// File: rtl/bias_pkg.sv
// bias_pkg: shared types and arithmetic helpers for the bias bank
// Contents: DATA_W_DEF default width, ld_state_t load-FSM states,
//           lane_lo lane-offset helper, sat_add saturating adder.
package bias_pkg;
    localparam int DATA_W_DEF = 18;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} ld_state_t;
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction
    // Operands arrive sign-extended to 64 bits; the result is clamped to the w-bit signed range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int w
    );
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction
endpackage

// File: rtl/bias_lane_sat.sv
// bias_lane_sat: one lane of add, saturate, then optional ReLU
// Ports: i_in/i_bias two's-complement operands, i_relu_en clamps negatives to 0,
//        o_res saturated DATA_W result.
module bias_lane_sat
    import bias_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] i_bias,
    input  logic              i_relu_en,
    output logic [DATA_W-1:0] o_res
);
    logic signed [63:0] w_sum;
    assign w_sum = sat_add({{(64 - DATA_W){i_in[DATA_W-1]}}, i_in},
                           {{(64 - DATA_W){i_bias[DATA_W-1]}}, i_bias}, DATA_W);
    assign o_res = (i_relu_en && w_sum < 0) ? '0 : w_sum[DATA_W-1:0];
endmodule

// File: rtl/bias_bank_add.sv
// bias_bank_add: runtime-loadable bias sets added to adder-tree vectors
// Ports: clk/rst (sync, active high); ld_* streams one set lane 0 first and
//        pulses ld_done; in_* valid/ready vector with its set index; relu_en
//        static mode; out_* registered result, one cycle after accept.
module bias_bank_add
    import bias_pkg::*;
#(
    parameter int N_ADDER_TREE = 16,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int N_SETS       = 32,
    parameter int SET_W        = $clog2(N_SETS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ld_start,
    input  logic [SET_W-1:0]               ld_set,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [DATA_W-1:0]              ld_data,
    output logic                           ld_done,
    input  logic                           relu_en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SET_W-1:0]               in_set,
    input  logic [N_ADDER_TREE*DATA_W-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_ADDER_TREE*DATA_W-1:0] out_data
);
    localparam int LANE_W = N_ADDER_TREE > 1 ? $clog2(N_ADDER_TREE) : 1;
    localparam int VEC_W  = N_ADDER_TREE * DATA_W;
    ld_state_t          r_state;
    logic [SET_W-1:0]   r_set;
    logic [LANE_W-1:0]  r_lane;
    logic [DATA_W-1:0]  r_bias [N_SETS][N_ADDER_TREE];
    logic               r_out_valid;
    logic [VEC_W-1:0]   r_out_data;
    logic [DATA_W-1:0]  w_bias [N_ADDER_TREE];
    logic [VEC_W-1:0]   w_res;
    logic               w_ld_ok, w_in_ok, w_wr, w_last, w_accept;
    // Indices past N_SETS only exist when N_SETS is not a power of two.
    assign w_ld_ok   = 32'(r_set) < N_SETS;
    assign w_in_ok   = 32'(in_set) < N_SETS;
    assign ld_ready  = r_state == LOAD;
    assign ld_done   = r_state == DONE;
    assign w_wr      = ld_ready && ld_valid;
    assign w_last    = 32'(r_lane) == N_ADDER_TREE - 1;
    // Only the set being rewritten is blocked, so a vector never sees a half-loaded set.
    assign in_ready  = (!r_out_valid || out_ready) && !(ld_ready && in_set == r_set);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_set   <= '0;
            r_lane  <= '0;
        end else begin
            case (r_state)
                IDLE: if (ld_start) begin
                    r_state <= LOAD;
                    r_set   <= ld_set;
                    r_lane  <= '0;
                end
                LOAD: if (ld_valid) begin
                    r_lane  <= r_lane + LANE_W'(1);
                    r_state <= w_last ? DONE : LOAD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++)
                for (int l = 0; l < N_ADDER_TREE; l++)
                    r_bias[s][l] <= '0;
        end else if (w_wr && w_ld_ok) begin
            r_bias[r_set][r_lane] <= ld_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
    for (genvar i = 0; i < N_ADDER_TREE; i++) begin : g_lane
        assign w_bias[i] = w_in_ok ? r_bias[in_set][i] : '0;
        bias_lane_sat #(.DATA_W(DATA_W)) u_lane (
            .i_in     (in_data[lane_lo(i, DATA_W) +: DATA_W]),
            .i_bias   (w_bias[i]),
            .i_relu_en(relu_en),
            .o_res    (w_res[lane_lo(i, DATA_W) +: DATA_W])
        );
    end
endmodule

// File: tb/tb_bias_bank_add.sv
// tb_bias_bank_add: randomized bench for bias_bank_add against a behavioural model
module tb_bias_bank_add;
    localparam int N    = 16;
    localparam int W    = 18;
    localparam int NS   = 32;
    localparam int SW   = 5;
    localparam int NW   = N * W;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));
    logic clk = 0, rst = 1, ld_start = 0, ld_valid = 0, relu_en = 0, in_valid = 0, out_ready = 1;
    logic [SW-1:0] ld_set = '0, in_set = '0;
    logic [W-1:0]  ld_data = '0;
    logic [NW-1:0] in_data = '0;
    logic          ld_ready, ld_done, in_ready, out_valid;
    logic [NW-1:0] out_data;
    int checks = 0, failures = 0;
    int m_bias [NS][N];
    int m_state = 0, m_set = 0, m_lane = 0;
    logic [NW-1:0] q [$];
    bit busy, er;

    bias_bank_add #(.N_ADDER_TREE(N), .DATA_W(W), .N_SETS(NS), .SET_W(SW)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_set(ld_set), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_done(ld_done), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_set(in_set), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] model(input int s, input logic [NW-1:0] d, input logic relu);
        logic [NW-1:0] r;
        int sum;
        r = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'($signed(d[i*W +: W])) + m_bias[s][i];
            sum = sum > MAXV ? MAXV : sum < MINV ? MINV : sum;
            if (relu && sum < 0) sum = 0;
            r[i*W +: W] = sum[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    // Observes the transfer about to happen on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            busy = q.size() != 0 && !out_ready;
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("out_data", out_data, q[0]);
                if (out_ready) void'(q.pop_front());
            end
            check("ld_ready", ld_ready, m_state == 1);
            check("ld_done", ld_done, m_state == 2);
            er = !busy && !(m_state == 1 && int'(in_set) == m_set);
            check("in_ready", in_ready, er);
            if (in_valid && er) q.push_back(model(in_set, in_data, relu_en));
            case (m_state)
                0: if (ld_start) begin
                    m_state = 1;
                    m_set   = ld_set;
                    m_lane  = 0;
                end
                1: if (ld_valid) begin
                    m_bias[m_set][m_lane] = int'($signed(ld_data));
                    m_lane++;
                    if (m_lane == N) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic reset_dut();
        rst = 1; ld_start = 0; ld_valid = 0; in_valid = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_state = 0;
        m_lane  = 0;
        foreach (m_bias[a, b]) m_bias[a][b] = 0;
        rst = 0;
    endtask

    task automatic load_set(input int s, input logic [W-1:0] v [N], input bit gaps, output int cyc);
        int k;
        bit acc;
        k = 0;
        cyc = 0;
        ld_start = 1; ld_set = SW'(s); ld_valid = 1; ld_data = v[0];
        while (!ld_done && cyc < 4 * N) begin
            @(negedge clk);
            acc = ld_valid && ld_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) k++;
            ld_start = gaps && cyc == 3;
            ld_set   = SW'(ld_start ? s + 1 : s);
            ld_valid = k < N && (!gaps || cyc % 2 == 0);
            ld_data  = v[k < N ? k : 0];
        end
        ld_valid = 0;
        ld_start = 0;
        check("ld_done_seen", ld_done, 1);
    endtask

    task automatic send(input int s, input logic [NW-1:0] d, output int t);
        bit acc;
        t = 0;
        in_valid = 1; in_set = SW'(s); in_data = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        in_valid = 0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  v [N];
        logic [NW-1:0] d;
        int cyc, t;
        reset_dut();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, '0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ld_done", ld_done, 0);

        foreach (v[i]) v[i] = W'(i * 4);
        load_set(3, v, 0, cyc);
        check("ld_done_latency", cyc, N + 1);
        @(posedge clk);
        #1;
        check("ld_done_one_cycle", ld_done, 0);
        d = {N{18'd100}};
        send(3, d, t);
        check("set3_lane0", out_data[W-1:0], 100);
        check("set3_lane15", out_data[NW-1 -: W], 160);

        foreach (v[i]) v[i] = W'($urandom);
        v[0] = 18'h1FFFF;
        v[1] = 18'h20000;
        v[2] = 18'd5;
        load_set(7, v, 0, cyc);
        d = rand_vec();
        d[W-1:0]     = 18'd10;
        d[2*W-1:W]   = 18'h3FFFB;
        d[3*W-1:2*W] = 18'h3FFEC;
        send(7, d, t);
        check("sat_hi", out_data[W-1:0], 18'h1FFFF);
        check("sat_lo", out_data[2*W-1:W], 18'h20000);
        check("no_relu_neg", out_data[3*W-1:2*W], 18'h3FFF1);
        relu_en = 1;
        send(7, d, t);
        check("relu_neg", out_data[3*W-1:2*W], 0);
        check("relu_after_sat", out_data[2*W-1:W], 0);
        check("relu_pos", out_data[W-1:0], 18'h1FFFF);
        relu_en = 0;

        fork
            for (int j = 0; j < 8; j++) send(3, rand_vec(), t);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        foreach (v[i]) v[i] = W'($urandom);
        fork
            load_set(5, v, 0, cyc);
            begin
                int ts;
                repeat (2) @(posedge clk);
                #1;
                send(6, rand_vec(), ts);
                check("ovl_set6_flow", ts, 1);
                send(6, rand_vec(), ts);
                send(5, rand_vec(), ts);
                check("ovl_set5_stall", ts, 14);
                send(6, rand_vec(), ts);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        ld_start = 1; ld_set = 9; ld_valid = 1; ld_data = W'($urandom);
        @(posedge clk);
        #1;
        ld_start = 0;
        repeat (7) begin
            ld_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        check("midload_ready", ld_ready, 1);
        reset_dut();
        check("midload_rst_ready", ld_ready, 0);
        d = rand_vec();
        send(9, d, t);
        check("rst_bias0_set9", out_data, d);
        d = rand_vec();
        send(3, d, t);
        check("rst_bias0_set3", out_data, d);

        foreach (v[i]) v[i] = W'($urandom);
        load_set(11, v, 1, cyc);
        d = rand_vec();
        send(11, d, t);
        send(12, d, t);
        check("ignored_start_set12", out_data, d);

        for (int r = 0; r < 4; r++) begin
            foreach (v[i]) v[i] = W'($urandom);
            load_set($urandom_range(0, NS - 1), v, $urandom_range(0, 1), cyc);
            relu_en = $urandom_range(0, 1);
            fork
                for (int j = 0; j < 30; j++) send($urandom_range(0, NS - 1), rand_vec(), t);
                begin
                    for (int c = 0; c < 40; c++) begin
                        out_ready = $urandom_range(0, 3) != 0;
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1;
                end
            join
        end
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
